ahb_ram_ws: RTL and testbench

- AHB-Lite slave RAM for the SoC fabric: 2^AWIDTH bytes, data bus DWIDTH bits, byte-lane write strobes derived from HSIZE/HADDR.
- Successor to the single-cycle 32-bit RAM. Adds:
  - parametrised data width (32/64);
  - programmable wait states;
  - HTRANS decoding;
  - two-cycle ERROR response for misaligned or oversized transfers;
  - asynchronous reset.

---
 rtl/ahb_ram_ws.sv | 145 ++++++++++++++
 tb/tb_ahb_ram_ws.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_ram_ws.sv
// AHB-Lite slave RAM with byte-lane strobes, programmable wait states and a two-cycle
// ERROR response for misaligned or oversized transfers.
module ahb_ram_ws #(
    parameter int unsigned AWIDTH      = 10,
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              HCLK_I,
    input  logic              HRESET_N_I,
    input  logic              HSEL_I,
    input  logic              HREADY_I,
    input  logic [1:0]        HTRANS_I,
    input  logic [2:0]        HSIZE_I,
    input  logic              HWRITE_I,
    input  logic [AWIDTH-1:0] HADDR_I,
    input  logic [DWIDTH-1:0] HWDATA_I,
    output logic [DWIDTH-1:0] HRDATA_O,
    output logic              HREADY_O,
    output logic              HRESP_O
);

    localparam int unsigned BYTES     = DWIDTH / 8;
    localparam int unsigned OFFW      = $clog2(BYTES);
    localparam int unsigned DEPTH     = 2 ** (AWIDTH - OFFW);
    localparam logic [2:0]  MAX_SIZE  = 3'(OFFW);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              ready_q;
    logic              resp_q;
    logic [AWIDTH-1:0] addr_q;
    logic [2:0]        size_q;
    logic              write_q;
    logic              err_q;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              accept;
    logic              acc_err;
    logic [AWIDTH-1:0] size_mask;
    logic [AWIDTH-OFFW-1:0] word_addr;
    logic [BYTES-1:0]  lane_en;
    logic              mem_we;
    int unsigned       lane_lo;
    int unsigned       lane_len;
    logic              unused_htrans;

    assign unused_htrans = HTRANS_I[0];

    assign accept    = HSEL_I & HREADY_I & HTRANS_I[1];
    assign size_mask = AWIDTH'((1 << HSIZE_I) - 1);
    assign acc_err   = (HSIZE_I > MAX_SIZE) || ((HADDR_I & size_mask) != '0);

    assign word_addr = addr_q[AWIDTH-1:OFFW];
    assign lane_lo   = 32'(addr_q[OFFW-1:0]);
    assign lane_len  = 32'(1) << size_q;

    always_comb begin
        lane_en = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            lane_en[i] = (i >= lane_lo) && (i < lane_lo + lane_len);
        end
    end

    always_ff @(posedge HCLK_I or negedge HRESET_N_I) begin
        if (!HRESET_N_I) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StData, StErr2: begin
                    if (accept) begin
                        addr_q  <= HADDR_I;
                        size_q  <= HSIZE_I;
                        write_q <= HWRITE_I;
                        err_q   <= acc_err;
                        if (acc_err) begin
                            state_q <= StErr1;
                            ready_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state_q <= StWait;
                            cnt_q   <= WAIT_LOAD;
                            ready_q <= 1'b0;
                            resp_q  <= 1'b0;
                        end else begin
                            state_q <= StData;
                            ready_q <= 1'b1;
                            resp_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StData;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StErr1: begin
                    state_q <= StErr2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b0;
                end
            endcase
        end
    end

    // Write commits on the edge ending DATA, so a pipelined read sees the new word.
    assign mem_we = (state_q == StData) && write_q && !err_q;

    always_ff @(posedge HCLK_I) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (lane_en[i]) begin
                    mem[word_addr][8*i +: 8] <= HWDATA_I[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA_O = (state_q == StData && !write_q) ? mem[word_addr] : '0;
    assign HREADY_O = ready_q;
    assign HRESP_O  = resp_q;

endmodule

// File: tb/tb_ahb_ram_ws.sv
// Directed bench for ahb_ram_ws: 32-bit zero-wait, 32-bit three-wait and 64-bit instances
// sharing one address/data bus, each with its own select and ready loop.
module tb_ahb_ram_ws;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sel;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [9:0]  haddr;
    logic [63:0] hwdata;
    logic [31:0] rdata0, rdata1;
    logic [63:0] rdata2;
    logic [2:0]  rdy, resp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ahb_ram_ws #(.AWIDTH(10), .DWIDTH(32), .WAIT_STATES(0)) u_ram0 (
        .HCLK_I(clk), .HRESET_N_I(rst_n), .HSEL_I(sel[0]), .HREADY_I(rdy[0]),
        .HTRANS_I(htrans), .HSIZE_I(hsize), .HWRITE_I(hwrite), .HADDR_I(haddr),
        .HWDATA_I(hwdata[31:0]), .HRDATA_O(rdata0), .HREADY_O(rdy[0]), .HRESP_O(resp[0])
    );

    ahb_ram_ws #(.AWIDTH(10), .DWIDTH(32), .WAIT_STATES(3)) u_ram1 (
        .HCLK_I(clk), .HRESET_N_I(rst_n), .HSEL_I(sel[1]), .HREADY_I(rdy[1]),
        .HTRANS_I(htrans), .HSIZE_I(hsize), .HWRITE_I(hwrite), .HADDR_I(haddr),
        .HWDATA_I(hwdata[31:0]), .HRDATA_O(rdata1), .HREADY_O(rdy[1]), .HRESP_O(resp[1])
    );

    ahb_ram_ws #(.AWIDTH(10), .DWIDTH(64), .WAIT_STATES(0)) u_ram2 (
        .HCLK_I(clk), .HRESET_N_I(rst_n), .HSEL_I(sel[2]), .HREADY_I(rdy[2]),
        .HTRANS_I(htrans), .HSIZE_I(hsize), .HWRITE_I(hwrite), .HADDR_I(haddr),
        .HWDATA_I(hwdata), .HRDATA_O(rdata2), .HREADY_O(rdy[2]), .HRESP_O(resp[2])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic addr_phase(input int dut, input logic wr, input logic [2:0] sz,
                              input logic [9:0] a);
        sel    = 3'(1 << dut);
        htrans = 2'b10;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic bus_idle();
        sel    = '0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = '0;
        haddr  = '0;
    endtask

    initial begin
        bus_idle();
        hwdata = '0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready0", 64'(rdy[0]), 64'd1);
        check_eq("rst_resp0", 64'(resp[0]), 64'd0);
        rst_n = 1'b1;
        sample();
        check_eq("rst_rdata0", 64'(rdata0), 64'd0);
        check_eq("rst_ready1", 64'(rdy[1]), 64'd1);
        check_eq("rst_ready2", 64'(rdy[2]), 64'd1);
        check_eq("rst_rdata2", rdata2, 64'd0);

        // Word write then back-to-back read
        tick(); addr_phase(0, 1'b1, 3'd2, 10'h10);
        tick(); hwdata = 64'hDEADBEEF; addr_phase(0, 1'b0, 3'd2, 10'h10);
        sample();
        check_eq("wr_ready", 64'(rdy[0]), 64'd1);
        check_eq("wr_resp", 64'(resp[0]), 64'd0);
        tick(); bus_idle();
        sample();
        check_eq("rd_word", 64'(rdata0), 64'hDEADBEEF);
        check_eq("rd_ready", 64'(rdy[0]), 64'd1);
        check_eq("rd_resp", 64'(resp[0]), 64'd0);

        // Byte write to lane 1
        tick(); addr_phase(0, 1'b1, 3'd0, 10'h11);
        tick(); hwdata = 64'h0000AA00; addr_phase(0, 1'b0, 3'd2, 10'h10);
        sample();
        check_eq("wr_rdata_zero", 64'(rdata0), 64'd0);
        tick(); bus_idle();
        sample();
        check_eq("rd_byte_merge", 64'(rdata0), 64'hDEADAAEF);

        // Halfword write to lanes 2..3
        tick(); addr_phase(0, 1'b1, 3'd1, 10'h12);
        tick(); hwdata = 64'h12340000; addr_phase(0, 1'b0, 3'd2, 10'h10);
        tick(); bus_idle();
        sample();
        check_eq("rd_half_merge", 64'(rdata0), 64'h1234AAEF);

        // Misaligned word write
        tick(); addr_phase(0, 1'b1, 3'd2, 10'h13);
        tick(); bus_idle(); hwdata = 64'hFFFFFFFF;
        sample();
        check_eq("mis_err1_ready", 64'(rdy[0]), 64'd0);
        check_eq("mis_err1_resp", 64'(resp[0]), 64'd1);
        tick();
        sample();
        check_eq("mis_err2_ready", 64'(rdy[0]), 64'd1);
        check_eq("mis_err2_resp", 64'(resp[0]), 64'd1);
        check_eq("mis_err2_rdata", 64'(rdata0), 64'd0);
        tick(); addr_phase(0, 1'b0, 3'd2, 10'h10);
        tick(); bus_idle();
        sample();
        check_eq("mis_unchanged", 64'(rdata0), 64'h1234AAEF);
        check_eq("mis_after_resp", 64'(resp[0]), 64'd0);

        // Oversized doubleword write, with a read pipelined into ERR2
        tick(); addr_phase(0, 1'b1, 3'd3, 10'h10);
        tick(); bus_idle();
        sample();
        check_eq("dw_err1_ready", 64'(rdy[0]), 64'd0);
        check_eq("dw_err1_resp", 64'(resp[0]), 64'd1);
        tick(); addr_phase(0, 1'b0, 3'd2, 10'h10);
        sample();
        check_eq("dw_err2_ready", 64'(rdy[0]), 64'd1);
        check_eq("dw_err2_resp", 64'(resp[0]), 64'd1);
        tick(); bus_idle();
        sample();
        check_eq("dw_unchanged", 64'(rdata0), 64'h1234AAEF);
        check_eq("dw_after_resp", 64'(resp[0]), 64'd0);

        // IDLE transfer type, then unselected NONSEQ write
        tick(); sel = 3'b001; htrans = 2'b00; hwrite = 1'b1; hsize = 3'd2; haddr = 10'h10;
        tick();
        sample();
        check_eq("idle_ready", 64'(rdy[0]), 64'd1);
        check_eq("idle_resp", 64'(resp[0]), 64'd0);
        tick(); sel = 3'b000; htrans = 2'b10;
        tick();
        sample();
        check_eq("unsel_ready", 64'(rdy[0]), 64'd1);
        tick(); addr_phase(0, 1'b0, 3'd2, 10'h10);
        tick(); bus_idle();
        sample();
        check_eq("no_write_unsel", 64'(rdata0), 64'h1234AAEF);

        // Three wait states: write
        tick(); addr_phase(1, 1'b1, 3'd2, 10'h10);
        tick(); bus_idle(); hwdata = 64'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            sample();
            check_eq($sformatf("ws_wr_wait%0d", k), 64'(rdy[1]), 64'd0);
            tick();
        end
        sample();
        check_eq("ws_wr_done", 64'(rdy[1]), 64'd1);
        check_eq("ws_wr_resp", 64'(resp[1]), 64'd0);

        // Three wait states: read, with a second transfer held during the waits
        tick(); addr_phase(1, 1'b0, 3'd2, 10'h10);
        tick(); addr_phase(1, 1'b0, 3'd2, 10'h20);
        for (int k = 0; k < 3; k++) begin
            sample();
            check_eq($sformatf("ws_rd_wait%0d", k), 64'(rdy[1]), 64'd0);
            tick();
        end
        bus_idle();
        sample();
        check_eq("ws_rd_ready", 64'(rdy[1]), 64'd1);
        check_eq("ws_rd_data", 64'(rdata1), 64'hCAFEF00D);
        tick();
        sample();
        check_eq("ws_no_second_ready", 64'(rdy[1]), 64'd1);
        check_eq("ws_no_second_rdata", 64'(rdata1), 64'd0);

        // Async reset in the middle of a waited write
        tick(); addr_phase(1, 1'b1, 3'd2, 10'h10);
        tick(); bus_idle(); hwdata = 64'h11111111;
        sample();
        check_eq("rst_pre_wait", 64'(rdy[1]), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_ready", 64'(rdy[1]), 64'd1);
        check_eq("rst_async_resp", 64'(resp[1]), 64'd0);
        check_eq("rst_async_rdata", 64'(rdata1), 64'd0);
        tick();
        rst_n = 1'b1;
        tick(); addr_phase(1, 1'b0, 3'd2, 10'h10);
        tick(); bus_idle();
        repeat (3) tick();
        sample();
        check_eq("rst_read_ready", 64'(rdy[1]), 64'd1);
        check_eq("rst_read_data", 64'(rdata1), 64'hCAFEF00D);

        // 64-bit instance: doubleword write, byte read returns full word
        tick(); addr_phase(2, 1'b1, 3'd3, 10'h08);
        tick(); hwdata = 64'h0123456789ABCDEF; addr_phase(2, 1'b0, 3'd0, 10'h0F);
        sample();
        check_eq("w64_ready", 64'(rdy[2]), 64'd1);
        check_eq("w64_resp", 64'(resp[2]), 64'd0);
        tick(); bus_idle();
        sample();
        check_eq("r64_word", rdata2, 64'h0123456789ABCDEF);
        check_eq("r64_resp", 64'(resp[2]), 64'd0);

        // 64-bit instance: word write to upper half
        tick(); addr_phase(2, 1'b1, 3'd2, 10'h0C);
        tick(); hwdata = 64'h5566778800000000; addr_phase(2, 1'b0, 3'd3, 10'h08);
        tick(); bus_idle();
        sample();
        check_eq("r64_upper_merge", rdata2, 64'h5566778889ABCDEF);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
